// File: rtl/seven_seg_scanner_if.sv
// Front-panel bus between the timekeeping datapath and the display scanner.
// Carries the load-side value/control signals and the active-low pin drives.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS  = 4,
  parameter int BRIGHT_BITS = 4
);
  logic [NUM_DIGITS*4-1:0] number;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    load;
  logic                    blank_lz;
  logic [BRIGHT_BITS-1:0]  brightness;
  logic [NUM_DIGITS-1:0]   io_sel;
  logic [7:0]              io_seg;

  modport master (
    output number, dp_mask, load, blank_lz, brightness,
    input  io_sel, io_seg
  );

  modport slave (
    input  number, dp_mask, load, blank_lz, brightness,
    output io_sel, io_seg
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode seven-segment scanner with frame-aligned
// double buffering, leading-zero blanking and PWM brightness.
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_HZ      = 100_000_000,
  parameter int REFRESH_HZ  = 200,
  parameter int BRIGHT_BITS = 4
) (
  input logic               clk,
  input logic               rst,
  seven_seg_scanner_if.slave bus
);

  localparam int DT_RAW = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int DIGIT_TICKS = (DT_RAW < 1) ? 1 : DT_RAW;
  localparam int TICK_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int NW = NUM_DIGITS * 4;

  logic [TICK_W-1:0]      tick;
  logic [IDX_W-1:0]       idx;
  logic [BRIGHT_BITS-1:0] pwm_cnt;
  logic [NW-1:0]          pend_num;
  logic [NW-1:0]          shad_num;
  logic [NUM_DIGITS-1:0]  pend_dp;
  logic [NUM_DIGITS-1:0]  shad_dp;
  logic                   tick_wrap;
  logic                   idx_last;
  logic                   frame_end;
  logic [NUM_DIGITS-1:0]  lz;
  logic [NUM_DIGITS-1:0]  sel_d;
  logic [7:0]             seg_d;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    unique case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
    endcase
    return g;
  endfunction

  assign tick_wrap = (tick == TICK_W'(DIGIT_TICKS - 1));
  assign idx_last  = (idx == IDX_W'(NUM_DIGITS - 1));
  assign frame_end = tick_wrap && idx_last;

  // Timebase: per-digit tick, digit index and free-running PWM phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick    <= '0;
      idx     <= '0;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + BRIGHT_BITS'(1);
      tick    <= tick_wrap ? '0 : tick + TICK_W'(1);
      if (tick_wrap)
        idx <= idx_last ? '0 : idx + IDX_W'(1);
    end
  end

  // Double buffer: load fills pending, frame end copies pending to shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_num <= '0;
      pend_dp  <= '0;
      shad_num <= '0;
      shad_dp  <= '0;
    end else begin
      if (frame_end) begin
        shad_num <= pend_num;
        shad_dp  <= pend_dp;
      end
      if (bus.load) begin
        pend_num <= bus.number;
        pend_dp  <= bus.dp_mask;
      end
    end
  end

  // Leading-zero map: digit i is a leading zero if it and all above are 0.
  always_comb begin : lz_map
    logic upper;
    upper = 1'b1;
    lz    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper = upper && (shad_num[4*i +: 4] == 4'h0);
      lz[i] = upper && (i != 0);
    end
  end

  // Select the current digit and gate it with the PWM duty.
  always_comb begin : decode
    logic [3:0] nib;
    logic       dp;
    logic       blank;
    nib   = '0;
    dp    = 1'b0;
    blank = 1'b0;
    sel_d = '1;
    seg_d = 8'hFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib   = shad_num[4*i +: 4];
        dp    = shad_dp[i];
        blank = lz[i] && bus.blank_lz;
      end
    end
    if (pwm_cnt < bus.brightness) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (idx == IDX_W'(i))
          sel_d[i] = 1'b0;
      seg_d = {~dp, blank ? 7'h7F : glyph(nib)};
    end
  end

  // Registered pin drives.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.io_sel <= '1;
      bus.io_seg <= 8'hFF;
    end else begin
      bus.io_sel <= sel_d;
      bus.io_seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a cycle-count reference model
// queues the expected pin state each edge; a monitor checks it.
module tb_seven_seg_scanner;

  localparam int N     = 4;
  localparam int BB    = 2;
  localparam int DT    = 8;
  localparam int FRAME = DT * N;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic clk;
  logic rst;

  seven_seg_scanner_if #(.NUM_DIGITS(N), .BRIGHT_BITS(BB)) bus();

  seven_seg_scanner #(
    .NUM_DIGITS(N),
    .CLK_HZ(800),
    .REFRESH_HZ(25),
    .BRIGHT_BITS(BB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [15:0] m_pnum = '0;
  logic [15:0] m_snum = '0;
  logic [3:0]  m_pdp = '0;
  logic [3:0]  m_sdp = '0;
  logic [11:0] sb[$];

  function automatic logic [7:0] exp_seg(int d);
    logic [15:0] hi;
    logic        blank;
    hi    = m_snum >> (4 * d);
    blank = bus.blank_lz && (d > 0) && (hi == 16'h0);
    return {~m_sdp[d], blank ? 7'h7F : GLYPH[int'(hi[3:0])]};
  endfunction

  // Reference model: n counts edges since reset; everything follows from it.
  initial begin
    forever begin
      logic [3:0] s;
      logic [7:0] g;
      int d;
      int p;
      @(posedge clk);
      if (rst) begin
        n = 0;
        m_pnum = '0;
        m_pdp = '0;
        m_snum = '0;
        m_sdp = '0;
        sb.push_back({4'hF, 8'hFF});
      end else begin
        d = (n / DT) % N;
        p = n % (1 << BB);
        s = 4'hF;
        g = 8'hFF;
        if (p < int'(bus.brightness)) begin
          s[d] = 1'b0;
          g = exp_seg(d);
        end
        sb.push_back({s, g});
        if ((n + 1) % FRAME == 0) begin
          m_snum = m_pnum;
          m_sdp = m_pdp;
        end
        if (bus.load) begin
          m_pnum = bus.number;
          m_pdp = bus.dp_mask;
        end
        n++;
      end
    end
  end

  // Monitor: compare the registered outputs against the queued expectation.
  initial begin
    forever begin
      logic [11:0] e;
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({bus.io_sel, bus.io_seg} !== e) begin
          errors++;
          $display("FAIL pins n=%0d: io_sel=%b io_seg=%b want io_sel=%b io_seg=%b",
                   n, bus.io_sel, bus.io_seg, e[11:8], e[7:0]);
        end
      end
    end
  end

  task automatic cyc(int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_load(logic [15:0] num, logic [3:0] dp);
    bus.number  = num;
    bus.dp_mask = dp;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
  endtask

  task automatic wait_phase(int r);
    int k;
    k = 0;
    while ((n % FRAME) != r && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if ((n % FRAME) != r) begin
      errors++;
      $display("FAIL phase_wait: phase=%0d want %0d", n % FRAME, r);
    end
  endtask

  initial begin
    logic [15:0] m;
    rst            = 1'b1;
    bus.number     = '0;
    bus.dp_mask    = '0;
    bus.load       = 1'b0;
    bus.blank_lz   = 1'b0;
    bus.brightness = 2'd3;
    cyc(3);
    rst = 1'b0;
    cyc(2 * FRAME);

    do_load(16'h12A4, 4'b0100);
    cyc(3 * FRAME);

    do_load(16'h1111, 4'b0000);
    cyc(2 * FRAME);
    wait_phase(20);
    do_load(16'h2222, 4'b0000);
    cyc(2 * FRAME);

    wait_phase(FRAME - 1);
    do_load(16'h3456, 4'b1001);
    cyc(2 * FRAME);

    bus.blank_lz = 1'b1;
    do_load(16'h0050, 4'b0000);
    cyc(2 * FRAME);
    do_load(16'h0000, 4'b0000);
    cyc(2 * FRAME);
    bus.blank_lz = 1'b0;
    cyc(2 * FRAME);

    bus.brightness = 2'd0;
    cyc(FRAME + 4);
    bus.brightness = 2'd1;
    cyc(FRAME);
    bus.brightness = 2'd3;
    do_load(16'hABCD, 4'b1111);
    cyc(2 * FRAME);
    wait_phase(13);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2 * FRAME);

    for (int it = 0; it < 250; it++) begin
      m = 16'hFFFF;
      m = m >> (4 * $urandom_range(0, 4));
      bus.number     = 16'($urandom) & m;
      bus.dp_mask    = 4'($urandom);
      bus.load       = ($urandom_range(0, 2) == 0);
      bus.blank_lz   = 1'($urandom);
      bus.brightness = 2'($urandom);
      rst            = ($urandom_range(0, 60) == 0);
      @(negedge clk);
      bus.load = 1'b0;
      rst      = 1'b0;
      cyc($urandom_range(0, 12));
    end

    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
